// File: rtl/conc_trace_pkg.sv
// Shared types for the concolic trace recorder: FSM states, entry layout and the
// default widths that match the stimulus player.
package conc_trace_pkg;

  localparam int PC_W_DEF  = 32;
  localparam int OBS_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // One recorded sample at the default widths: {cycle index, observation}.
  typedef struct packed {
    logic [PC_W_DEF-1:0]  cycle;
    logic [OBS_W_DEF-1:0] obs;
  } entry_t;

endpackage

// File: rtl/conc_trace_mem.sv
// Trace buffer storage: DEPTH x W register array, one write port, one async read port.
module conc_trace_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 34
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/conc_trace_recorder.sv
// Records {cycle, obs} samples during a capture window into a FWFT FIFO drained over valid/ready.
// Optional build macro CONC_RLE_EN: only push samples whose obs differs from the last pushed one.
module conc_trace_recorder
  import conc_trace_pkg::*;
#(
  parameter int OBS_W = OBS_W_DEF,
  parameter int DEPTH = 16,
  parameter int PC_W  = PC_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cap_en,
  input  logic                   obs_valid,
  input  logic [OBS_W-1:0]       obs_in,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [PC_W+OBS_W-1:0]  rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   lost,
  output logic                   done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PC_W + OBS_W;

  state_t          state_q, state_d;
  logic [PC_W-1:0] cycle_q;
  logic [AW-1:0]   wr_ptr, rd_ptr, head_ptr_d;
  logic [CW-1:0]   count_d, cnt_after_pop;
  logic [EW-1:0]   wdata, head_rdata;
  logic            in_cap, start_cap, want, push, pop, done_d;

  assign in_cap    = (state_q == CAPTURE);
  assign start_cap = (state_q == IDLE) && cap_en;
  assign rd_valid  = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign pop       = rd_valid && rd_ready;
  // A concurrent pop frees the slot, so a full FIFO still accepts the push.
  assign push      = want && (!full || pop);
  assign wdata     = {cycle_q, obs_in};

`ifdef CONC_RLE_EN
  logic             first_q;
  logic [OBS_W-1:0] last_obs_q;

  assign want = in_cap && obs_valid && (first_q || (obs_in != last_obs_q));

  // Last value only tracks accepted pushes so a dropped change is retried later.
  always_ff @(posedge clock) begin
    if (reset) begin
      first_q    <= 1'b0;
      last_obs_q <= '0;
    end else if (start_cap) begin
      first_q    <= 1'b1;
    end else if (push) begin
      first_q    <= 1'b0;
      last_obs_q <= obs_in;
    end
  end
`else
  assign want = in_cap && obs_valid;
`endif

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:    if (cap_en) state_d = CAPTURE;
      CAPTURE: if (!cap_en) state_d = DRAIN;
      DRAIN: begin
        if (cap_en) begin
          state_d = CAPTURE;
        end else if (count == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count + CW'(1);
      2'b01:   count_d = count - CW'(1);
      default: count_d = count;
    endcase
  end

  // Head after this edge: either an entry already stored, or the one being written into an empty FIFO.
  assign head_ptr_d    = pop ? rd_ptr + AW'(1) : rd_ptr;
  assign cnt_after_pop = count - CW'(pop);

  conc_trace_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clock (clock),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (head_ptr_d),
    .rdata (head_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cycle_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
      lost    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      count   <= count_d;
      if (start_cap)   cycle_q <= '0;
      else if (in_cap) cycle_q <= cycle_q + PC_W'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (want && full && !pop) lost <= 1'b1;
      if (cnt_after_pop != '0) rd_data <= head_rdata;
      else if (push)            rd_data <= wdata;
    end
  end

endmodule

// File: tb/tb_conc_trace_recorder.sv
// Randomized + directed bench for conc_trace_recorder with a queue-based reference model and scoreboard.
module tb_conc_trace_recorder;
  import conc_trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int PC_W  = PC_W_DEF;
  localparam int OBS_W = OBS_W_DEF;
`ifdef CONC_RLE_EN
  localparam bit RLE = 1'b1;
`else
  localparam bit RLE = 1'b0;
`endif

  logic clock = 1'b0, reset = 1'b1, cap_en = 1'b0, obs_valid = 1'b0, rd_ready = 1'b0;
  logic [OBS_W-1:0]      obs_in = '0;
  logic                  rd_valid, full, lost, done;
  logic [PC_W+OBS_W-1:0] rd_data;
  logic [4:0]            count;

  int n_vec = 0, n_fail = 0;
  bit mon_on = 1'b0;

  always #5 clock = ~clock;

  conc_trace_recorder #(.OBS_W(OBS_W), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clock(clock), .reset(reset), .cap_en(cap_en), .obs_valid(obs_valid), .obs_in(obs_in),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .count(count),
    .full(full), .lost(lost), .done(done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: trace buffer as a queue, window state as a plain enum.
  typedef enum {M_IDLE, M_CAP, M_DRAIN} mst_e;
  mst_e             mst = M_IDLE;
  entry_t           mq[$];
  entry_t           exp_q[$];
  logic [PC_W-1:0]  m_cycle = '0;
  logic [OBS_W-1:0] m_last = '0;
  bit               m_lost = 1'b0, m_done = 1'b0, m_first = 1'b0;

  always @(posedge clock) begin
    int     pre;
    bit     mpop, mwant, mpush;
    entry_t e;
    if (reset) begin
      mst = M_IDLE; mq.delete(); exp_q.delete();
      m_cycle = '0; m_last = '0; m_lost = 1'b0; m_done = 1'b0; m_first = 1'b0;
    end else begin
      pre   = mq.size();
      mpop  = (pre != 0) && rd_ready;
      mwant = (mst == M_CAP) && obs_valid && (!RLE || m_first || (obs_in != m_last));
      mpush = mwant && ((pre < DEPTH) || mpop);
      if (mwant && !mpush) m_lost = 1'b1;
      e.cycle = m_cycle;
      e.obs   = obs_in;
      if (mpop) void'(mq.pop_front());
      if (mpush) begin
        mq.push_back(e);
        exp_q.push_back(e);
        m_first = 1'b0;
        m_last  = obs_in;
      end
      m_done = 1'b0;
      case (mst)
        M_IDLE:  if (cap_en) begin mst = M_CAP; m_cycle = '0; m_first = 1'b1; end
        M_CAP:   begin m_cycle = m_cycle + 1; if (!cap_en) mst = M_DRAIN; end
        M_DRAIN: begin
          if (cap_en) mst = M_CAP;
          else if (pre == 0) begin mst = M_IDLE; m_done = 1'b1; end
        end
        default: mst = M_IDLE;
      endcase
    end
  end

  // Monitor: status every cycle, head data against scoreboard, pop on handshake.
  always @(negedge clock) begin
    if (mon_on && !reset) begin
      check("rd_valid", rd_valid, mq.size() != 0);
      check("count", count, mq.size());
      check("full", full, mq.size() == DEPTH);
      check("lost", lost, m_lost);
      check("done", done, m_done);
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL rd_data: got %0h with rd_valid=1, expected no entry", rd_data);
        end else begin
          check("rd_data", rd_data, exp_q[0]);
          if (rd_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cap_en = 1'b0; obs_valid = 1'b0; rd_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic drain(input string name, input int exp_pulses);
    int pulses;
    pulses = 0;
    cap_en = 1'b0; obs_valid = 1'b0; rd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) pulses++;
    end
    check(name, pulses, exp_pulses);
    check({name, "_empty"}, count, 0);
  endtask

  task automatic capture_n(input int n);
    cap_en = 1'b1; obs_valid = 1'b0; tick();
    obs_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      obs_in = OBS_W'(i & 1);
      tick();
    end
  endtask

  initial begin
    logic [OBS_W-1:0] seq [6];
    int               rr_pct;

    do_reset();
    mon_on = 1'b1;
    check("reset_rd_data", rd_data, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_count", count, 0);
    check("reset_done", done, 0);

    // In-order capture with 1-cycle latency
    cap_en = 1'b1; rd_ready = 1'b1; tick();
    obs_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      obs_in = OBS_W'(i);
      tick();
      check("t1_head", rd_data, {PC_W'(i), OBS_W'(i)});
    end
    drain("t1_done", 1);

    // Fill, push+pop while full, then overflow
    do_reset();
    rd_ready = 1'b0;
    capture_n(16);
    check("t3_count", count, 16);
    check("t3_full", full, 1);
    check("t3_lost", lost, 0);
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin obs_in = ~obs_in; tick(); end
    check("t3_count_pp", count, 16);
    check("t3_lost_pp", lost, 0);
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin obs_in = ~obs_in; tick(); end
    check("t2_lost", lost, 1);
    check("t2_count", count, 16);
    drain("t2_done", 1);

    // Drain of 5 entries
    do_reset();
    rd_ready = 1'b0;
    capture_n(5);
    check("t4_count", count, 5);
    drain("t4_done", 1);

    // Reset mid-capture
    do_reset();
    rd_ready = 1'b0;
    capture_n(7);
    reset = 1'b1; tick(); reset = 1'b0;
    check("t5_count", count, 0);
    check("t5_rd_valid", rd_valid, 0);
    check("t5_lost", lost, 0);
    cap_en = 1'b1; obs_valid = 1'b0; tick();
    obs_valid = 1'b1; obs_in = 2'b10; tick();
    check("t5_cycle0", rd_data, {PC_W'(0), 2'b10});
    drain("t5_done", 1);

    // Change-only sequence
    do_reset();
    rd_ready = 1'b0;
    seq = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01};
    cap_en = 1'b1; tick();
    obs_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin obs_in = seq[i]; tick(); end
    cap_en = 1'b0; obs_valid = 1'b0; tick();
    check("t6_count", count, RLE ? 3 : 6);
    check("t6_head", rd_data, {PC_W'(0), 2'b01});
    drain("t6_done", 1);

    // Random traffic
    do_reset();
    rr_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) rr_pct = $urandom_range(10, 90);
      if ($urandom_range(0, 9) == 0) cap_en = ~cap_en;
      obs_valid = ($urandom_range(0, 3) != 0);
      obs_in    = OBS_W'($urandom);
      rd_ready  = ($urandom_range(0, 99) < rr_pct);
      reset     = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0; cap_en = 1'b0; obs_valid = 1'b0; rd_ready = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    check("rand_final_empty", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
